// File: rtl/regfile_arbiter_if.sv
// Bundle between the two requesters, the arbiter and the single-port register file.
// Per-port signals are packed arrays indexed by port number (0 = system controller, 1 = host).
interface regfile_arbiter_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic [1:0]             p_req;
    logic [1:0]             p_we;
    logic [1:0][ADDR_W-1:0] p_addr;
    logic [1:0][DATA_W-1:0] p_wdata;
    logic [1:0]             p_gnt;
    logic [1:0][DATA_W-1:0] p_rdata;
    logic [1:0]             p_rvalid;
    logic [1:0]             p_err;

    logic                   rf_wr_en;
    logic                   rf_rd_en;
    logic [ADDR_W-1:0]      rf_addr;
    logic [DATA_W-1:0]      rf_wdata;
    logic [DATA_W-1:0]      rf_rd_data;
    logic                   rf_rd_vld;

    modport slave (
        input  p_req, p_we, p_addr, p_wdata, rf_rd_data, rf_rd_vld,
        output p_gnt, p_rdata, p_rvalid, p_err, rf_wr_en, rf_rd_en, rf_addr, rf_wdata
    );

    modport master (
        output p_req, p_we, p_addr, p_wdata, rf_rd_data, rf_rd_vld,
        input  p_gnt, p_rdata, p_rvalid, p_err, rf_wr_en, rf_rd_en, rf_addr, rf_wdata
    );
endinterface

// File: rtl/regfile_arbiter.sv
// Two-port round-robin arbiter in front of a single-port register file.
// Serialises commands, routes read data back to the issuing port and closes out lost reads.
module regfile_arbiter #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = 8
) (
    input logic              clk,
    input logic              rstn,
    regfile_arbiter_if.slave bus
);
    localparam int NUM_PORTS = 2;
    localparam int CNT_W     = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_WR, S_RD, S_RD_WAIT} state_e;

    state_e                 state_q, state_d;
    logic                   owner_q, owner_d;
    logic                   last_q, last_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [NUM_PORTS-1:0]   gnt_q, gnt_d;
    logic                   wr_en_q, wr_en_d;
    logic                   rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [DATA_W-1:0]      wdata_q, wdata_d;

    logic                   grant_any;
    logic                   grant_sel;
    logic                   vld_hit;
    logic                   timeout;
    logic                   rsp_fire;
    logic                   rsp_err;
    logic [DATA_W-1:0]      rsp_data;

    // On contention the port that did not win last time goes first.
    assign grant_any = |bus.p_req;
    always_comb begin
        grant_sel = 1'b0;
        unique case (bus.p_req)
            2'b01:   grant_sel = 1'b0;
            2'b10:   grant_sel = 1'b1;
            2'b11:   grant_sel = ~last_q;
            default: grant_sel = 1'b0;
        endcase
    end

    // Valid on the final count beats the timeout.
    assign vld_hit = (state_q == S_RD_WAIT) && bus.rf_rd_vld;
    assign timeout = (state_q == S_RD_WAIT) && !bus.rf_rd_vld && (cnt_q == CNT_LAST);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            gnt_q   <= '0;
            wr_en_q <= 1'b0;
            rd_en_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            wr_en_q <= wr_en_d;
            rd_en_q <= rd_en_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (grant_any) begin
                    owner_d = grant_sel;
                    last_d  = grant_sel;
                    state_d = bus.p_we[grant_sel] ? S_WR : S_RD;
                end
            end
            S_WR: state_d = S_IDLE;
            S_RD: begin
                state_d = S_RD_WAIT;
                cnt_d   = '0;
            end
            S_RD_WAIT: begin
                if (vld_hit || timeout) state_d = S_IDLE;
                else                    cnt_d   = cnt_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Next values of the registered outputs; rf_* fall back to zero unless driven here.
    always_comb begin
        gnt_d    = '0;
        wr_en_d  = 1'b0;
        rd_en_d  = 1'b0;
        addr_d   = '0;
        wdata_d  = '0;
        rsp_fire = 1'b0;
        rsp_err  = 1'b0;
        rsp_data = '0;
        unique case (state_q)
            S_IDLE: begin
                if (grant_any) begin
                    gnt_d[grant_sel] = 1'b1;
                    addr_d           = bus.p_addr[grant_sel];
                    if (bus.p_we[grant_sel]) begin
                        wr_en_d = 1'b1;
                        wdata_d = bus.p_wdata[grant_sel];
                    end else begin
                        rd_en_d = 1'b1;
                    end
                end
            end
            S_RD: addr_d = addr_q;
            S_RD_WAIT: begin
                if (vld_hit) begin
                    rsp_fire = 1'b1;
                    rsp_data = bus.rf_rd_data;
                end else if (timeout) begin
                    rsp_fire = 1'b1;
                    rsp_err  = 1'b1;
                end else begin
                    addr_d = addr_q;
                end
            end
            default: ;
        endcase
    end

    // Per-port response registers; only the owner's lane ever moves.
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_rsp
        logic              hit;
        logic              rvalid_q;
        logic              err_q;
        logic [DATA_W-1:0] rdata_q;

        assign hit = rsp_fire && (owner_q == 1'(p));

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                rvalid_q <= 1'b0;
                err_q    <= 1'b0;
                rdata_q  <= '0;
            end else begin
                rvalid_q <= hit;
                err_q    <= hit && rsp_err;
                if (hit) rdata_q <= rsp_data;
            end
        end

        assign bus.p_rvalid[p] = rvalid_q;
        assign bus.p_err[p]    = err_q;
        assign bus.p_rdata[p]  = rdata_q;
    end

    assign bus.p_gnt    = gnt_q;
    assign bus.rf_wr_en = wr_en_q;
    assign bus.rf_rd_en = rd_en_q;
    assign bus.rf_addr  = addr_q;
    assign bus.rf_wdata = wdata_q;
endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter: a cycle-accounting transaction model checked every
// cycle, plus hand-computed literal expectations on grants, latencies and read data.
module tb_regfile_arbiter;
    localparam int DW      = 8;
    localparam int AW      = 4;
    localparam int TIMEOUT = 8;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   cyc      = 0;
    int   checks   = 0;
    int   failures = 0;

    logic [DW-1:0] mem [16];
    logic [1:0]    gexp [8];

    regfile_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus();

    regfile_arbiter #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TIMEOUT)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endfunction

    function automatic logic [63:0] act_vec();
        return {28'd0, bus.p_gnt, bus.p_rvalid, bus.p_err, bus.p_rdata,
                bus.rf_wr_en, bus.rf_rd_en, bus.rf_addr, bus.rf_wdata};
    endfunction

    // Transaction model: decides each grant from the round-robin rule and accounts for
    // the cycles each command occupies the register file.
    logic [1:0]         e_gnt, e_rv, e_err;
    logic [1:0][DW-1:0] e_rdata;
    logic               e_wr, e_rd;
    logic [AW-1:0]      e_addr, rd_addr;
    logic [DW-1:0]      e_wdata;
    int                 free_cyc, rd_issue, own;
    bit                 rd_pend, last;

    initial begin
        e_gnt = '0; e_rv = '0; e_err = '0; e_rdata = '0;
        e_wr = 1'b0; e_rd = 1'b0; e_addr = '0; e_wdata = '0; rd_addr = '0;
        free_cyc = 0; rd_issue = 0; own = 0; rd_pend = 0; last = 1;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                chk("reset_state", act_vec(), 64'd0);
                e_gnt = '0; e_rv = '0; e_err = '0; e_rdata = '0;
                e_wr = 1'b0; e_rd = 1'b0; e_addr = '0; e_wdata = '0;
                rd_pend = 0; last = 1; free_cyc = 0;
            end else begin
                chk("model_cycle", act_vec(),
                    {28'd0, e_gnt, e_rv, e_err, e_rdata, e_wr, e_rd, e_addr, e_wdata});
                e_gnt = '0; e_rv = '0; e_err = '0;
                e_wr = 1'b0; e_rd = 1'b0; e_addr = '0; e_wdata = '0;
                if (rd_pend) begin
                    if (cyc == rd_issue) begin
                        e_addr = rd_addr;
                    end else if (bus.rf_rd_vld) begin
                        e_rv[own] = 1'b1; e_rdata[own] = bus.rf_rd_data;
                        rd_pend = 0; free_cyc = cyc + 1;
                    end else if (cyc == rd_issue + TIMEOUT) begin
                        e_rv[own] = 1'b1; e_err[own] = 1'b1; e_rdata[own] = '0;
                        rd_pend = 0; free_cyc = cyc + 1;
                    end else begin
                        e_addr = rd_addr;
                    end
                end else if (cyc >= free_cyc && bus.p_req != 2'b00) begin
                    if (bus.p_req == 2'b11) own = last ? 0 : 1;
                    else                    own = bus.p_req[1] ? 1 : 0;
                    last = (own == 1);
                    e_gnt[own] = 1'b1;
                    e_addr     = bus.p_addr[own];
                    if (bus.p_we[own]) begin
                        e_wr = 1'b1; e_wdata = bus.p_wdata[own]; free_cyc = cyc + 2;
                    end else begin
                        e_rd = 1'b1; rd_pend = 1; rd_issue = cyc + 1; rd_addr = bus.p_addr[own];
                    end
                end
            end
        end
    end

    task automatic wait_gnt(input int p, output int tg);
        bit seen = 0;
        tg = -1;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (bus.p_gnt[p]) begin seen = 1; tg = cyc; end
        end
        if (!seen) chk("gnt_wait_expired", 64'd0, 64'd1);
    endtask

    task automatic do_write(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int t0, tg;
        bus.p_req[p] = 1'b1; bus.p_we[p] = 1'b1; bus.p_addr[p] = a; bus.p_wdata[p] = d;
        t0 = cyc;
        wait_gnt(p, tg);
        chk("wr_gnt_latency", 64'(tg - t0), 64'd1);
        chk("wr_en", 64'(bus.rf_wr_en), 64'd1);
        chk("wr_addr", 64'(bus.rf_addr), 64'(a));
        chk("wr_wdata", 64'(bus.rf_wdata), 64'(d));
        mem[a] = d;
        @(posedge clk); #1;
        bus.p_req[p] = 1'b0;
        @(negedge clk);
        chk("wr_en_one_cycle", 64'(bus.rf_wr_en), 64'd0);
        @(posedge clk); #1;
    endtask

    // k = cycles from rf_rd_en to rf_rd_vld; k = 0 means the register file never answers.
    task automatic do_read(input int p, input logic [AW-1:0] a, input int k,
                           input logic [DW-1:0] exp_d, input logic exp_err);
        int t0, tg, tr, lat;
        bit seen = 0;
        bus.p_req[p] = 1'b1; bus.p_we[p] = 1'b0; bus.p_addr[p] = a;
        t0 = cyc;
        wait_gnt(p, tg);
        chk("rd_gnt_latency", 64'(tg - t0), 64'd1);
        chk("rd_en", 64'(bus.rf_rd_en), 64'd1);
        chk("rd_addr", 64'(bus.rf_addr), 64'(a));
        @(posedge clk); #1;
        bus.p_req[p] = 1'b0;
        if (k > 0) begin
            repeat (k - 1) begin @(posedge clk); #1; end
            bus.rf_rd_vld = 1'b1; bus.rf_rd_data = mem[a];
            @(posedge clk); #1;
            bus.rf_rd_vld = 1'b0; bus.rf_rd_data = '0;
        end
        tr = -1;
        for (int i = 0; i < TIMEOUT + 6 && !seen; i++) begin
            @(negedge clk);
            if (bus.p_rvalid[p]) begin
                seen = 1; tr = cyc;
                chk("rd_rdata", 64'(bus.p_rdata[p]), 64'(exp_d));
                chk("rd_err", 64'(bus.p_err[p]), 64'(exp_err));
                chk("rd_other_port_quiet", 64'(bus.p_rvalid[1-p]), 64'd0);
            end
        end
        lat = (k > 0) ? k + 1 : TIMEOUT + 1;
        if (!seen) chk("rd_rvalid_wait_expired", 64'd0, 64'd1);
        else       chk("rd_rvalid_latency", 64'(tr - tg), 64'(lat));
        @(posedge clk); #1;
    endtask

    initial begin
        int tg, rv_seen;
        gexp[0] = 2'b00; gexp[1] = 2'b01; gexp[2] = 2'b00; gexp[3] = 2'b10;
        gexp[4] = 2'b00; gexp[5] = 2'b01; gexp[6] = 2'b00; gexp[7] = 2'b10;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        bus.p_req = '0; bus.p_we = '0; bus.p_addr = '0; bus.p_wdata = '0;
        bus.rf_rd_vld = 1'b0; bus.rf_rd_data = '0;

        repeat (2) @(negedge clk);
        chk("reset_outputs_zero", act_vec(), 64'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;

        do_write(0, 4'd5, 8'hA7);
        do_write(0, 4'd2, 8'h3C);
        do_write(1, 4'd9, 8'h5A);
        do_read(1, 4'd2, 1, 8'h3C, 1'b0);
        do_read(0, 4'd9, 3, 8'h5A, 1'b0);
        do_read(0, 4'd5, 0, 8'h00, 1'b1);
        do_read(0, 4'd5, TIMEOUT, 8'hA7, 1'b0);

        // Stray valid while idle.
        bus.rf_rd_vld = 1'b1; bus.rf_rd_data = 8'hEE;
        @(posedge clk); #1;
        bus.rf_rd_vld = 1'b0; bus.rf_rd_data = '0;
        @(negedge clk);
        chk("stray_idle_no_rvalid", 64'(bus.p_rvalid), 64'd0);
        @(posedge clk); #1;

        // Stray valid during a write.
        bus.p_req[1] = 1'b1; bus.p_we[1] = 1'b1; bus.p_addr[1] = 4'd7; bus.p_wdata[1] = 8'h11;
        @(posedge clk); #1;
        bus.rf_rd_vld = 1'b1; bus.rf_rd_data = 8'hEE;
        @(negedge clk);
        chk("stray_wr_gnt", 64'(bus.p_gnt), 64'd2);
        @(posedge clk); #1;
        bus.p_req[1] = 1'b0; bus.rf_rd_vld = 1'b0; bus.rf_rd_data = '0;
        @(negedge clk);
        chk("stray_wr_no_rvalid", 64'(bus.p_rvalid), 64'd0);
        @(posedge clk); #1;

        // Reset while p0's read is outstanding.
        bus.p_req[0] = 1'b1; bus.p_we[0] = 1'b0; bus.p_addr[0] = 4'd3;
        wait_gnt(0, tg);
        @(posedge clk); #1;
        bus.p_req[0] = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b0;
        #1;
        chk("midread_reset_outputs", act_vec(), 64'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rstn = 1'b1;

        // Both ports write continuously: p0 first after reset, then alternate.
        bus.p_req = 2'b11; bus.p_we = 2'b11;
        bus.p_addr[0] = 4'd1; bus.p_wdata[0] = 8'h10;
        bus.p_addr[1] = 4'd2; bus.p_wdata[1] = 8'h20;
        rv_seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("contention_gnt", 64'(bus.p_gnt), 64'(gexp[i]));
            if (|bus.p_rvalid) rv_seen++;
        end
        chk("no_rvalid_after_reset", 64'(rv_seen), 64'd0);
        @(posedge clk); #1;
        bus.p_req = 2'b00;
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/regfile_arbiter.md
# regfile_arbiter

Two-port arbiter that shares the single-port register file between the system controller (port 0) and a second requester such as a debug/config host (port 1). It serializes read and write commands with round-robin priority, drives the register file's WrEn/RdEn/Addr/Wr_D, and routes Rd_D/Rd_D_Vld back to the requester that issued the read. A read that never completes is closed out by a timeout and an error response.

## Interface
- DATA_W, 8, register data width
- ADDR_W, 4, register address width (16 entries)
- TIMEOUT, 8, max cycles spent waiting for rf_rd_vld (≥2)
- clk  in  1  clock
- rstn  in  1  reset; asynchronous, active-low
- pN_req  in  1  port N (N=0,1) command request; held with fields stable until pN_gnt seen
- pN_we  in  1  1 = write, 0 = read
- pN_addr  in  ADDR_W  command address
- pN_wdata  in  DATA_W  write data
- pN_gnt  out  1  one-cycle grant; command is on the rf_* bus in the same cycle
- pN_rdata  out  DATA_W  read data (valid when pN_rvalid=1)
- pN_rvalid  out  1  one-cycle read response strobe
- pN_err  out  1  one-cycle, coincident with pN_rvalid on read timeout
- rf_wr_en  out  1  register file write enable
- rf_rd_en  out  1  register file read enable
- rf_addr  out  ADDR_W  register file address
- rf_wdata  out  DATA_W  register file write data
- rf_rd_data  in  DATA_W  register file read data
- rf_rd_vld  in  1  register file read data valid

## Operation
- All outputs registered. Reset (async, rstn=0): state IDLE, every output 0, cnt 0, last_grant=1 (port 0 wins first contention); an outstanding read is dropped with no rvalid.
- States: IDLE, WR, RD, RD_WAIT.
- IDLE: sample requests. None -> stay. One -> grant it. Both -> grant port ≠ last_grant; last_grant updated on every grant.
- On grant (IDLE edge): latch owner; pN_gnt=1, rf_addr=pN_addr; write -> rf_wr_en=1, rf_wdata=pN_wdata, go WR; read -> rf_rd_en=1, rf_wdata=0, go RD.
- WR (1 cycle, gnt+command visible): next IDLE; all rf_* return to 0.
- RD (1 cycle, gnt+rf_rd_en visible): next RD_WAIT, cnt=0; rf_addr held during RD_WAIT, rf_rd_en=0.
- RD_WAIT: rf_rd_vld=1 -> owner's pN_rdata=rf_rd_data, pN_rvalid=1 next cycle, go IDLE. Else cnt++; if cnt==TIMEOUT-1 and no vld -> pN_rdata=0, pN_rvalid=1, pN_err=1 next cycle, go IDLE. vld on the final count wins over timeout.
- rf_rd_vld outside RD_WAIT is ignored. Non-owner port's rvalid/err/rdata never change.
- pN_rdata holds last returned value until next response to that port.
- Requests arriving while busy wait; no queue, no drop (req is level).

## Timing
- Grant latency: req high in IDLE at cycle T -> gnt + rf command in cycle T+1.
- Write: rf_wr_en single cycle T+1; back in IDLE at T+2. Same port back-to-back writes every 2 cycles.
- Read with rf_rd_vld arriving k cycles after rf_rd_en (k≥1, k≤TIMEOUT): pN_rvalid at cycle T+2+k; IDLE coincides with rvalid cycle, so a new grant can appear at T+3+k.
- Timeout: pN_rvalid+pN_err at T+2+TIMEOUT.
- Requester must drop req (or present next command) on the edge after gnt; arbiter never samples req during WR/RD, so a held req is not double-granted.
- Only one of rf_wr_en/rf_rd_en ever high; at most one gnt per cycle.

## Test plan
- Reset mid-read: p0 read addr 3, assert rstn=0 in RD_WAIT -> all outputs 0 immediately, no p0_rvalid after release, next p1 req granted first? No: p0 wins (last_grant=1).
- Single write: p0 we=1 addr 5 wdata 0xA7 -> p0_gnt, rf_wr_en=1, rf_addr=5, rf_wdata=0xA7 for exactly 1 cycle at T+1.
- Read, model with k=1: p1 read addr 2, memory 0x3C -> p1_rvalid=1, p1_rdata=0x3C at T+3; p0 outputs unchanged.
- Contention: p0 and p1 both write continuously -> grants alternate p0,p1,p0,p1 every 2 cycles, starting with p0 after reset.
- Timeout: p0 read, rf_rd_vld never asserted, TIMEOUT=8 -> p0_rvalid=p0_err=1, p0_rdata=0 at T+10; vld at exactly cycle T+9 instead -> rvalid with data, err=0.
- Stray vld: rf_rd_vld pulse in IDLE and during write -> no rvalid on either port.
